// File: rtl/sal_sched_pkg.sv
// Shared types and helpers for the scheduler-side DFI bus arbitration logic.
package sal_sched_pkg;

  typedef enum logic [1:0] {ST_RD, ST_WR, ST_R2W, ST_W2R} arb_state_t;
  typedef enum logic {DIR_RD, DIR_WR} bus_dir_t;

  localparam int TMR_W = 4;

  // tCCD of 0 or 1 both mean back-to-back, so the spacing counter reloads with max(tCCD-1, 0).
  function automatic logic [TMR_W-1:0] ccd_gap(input logic [TMR_W-1:0] t_ccd);
    return (t_ccd == '0) ? '0 : t_ccd - 1'b1;
  endfunction

endpackage

// File: rtl/sal_rw_turnaround_arb_if.sv
// Request/grant bundle between the bank schedulers and the read/write turnaround arbiter.
interface sal_rw_turnaround_arb_if;
  import sal_sched_pkg::*;

  logic             rd_req_i;
  logic             wr_req_i;
  logic [TMR_W-1:0] t_ccd_i;
  logic [TMR_W-1:0] t_rtw_i;
  logic [TMR_W-1:0] t_wtr_i;
  logic             rd_ret_i;
  logic             rd_gnt_o;
  logic             wr_gnt_o;
  logic             bus_dir_o;
  logic [TMR_W-1:0] rd_cred_o;
  logic             err_o;

  modport master (
    output rd_req_i, wr_req_i, t_ccd_i, t_rtw_i, t_wtr_i, rd_ret_i,
    input  rd_gnt_o, wr_gnt_o, bus_dir_o, rd_cred_o, err_o
  );

  modport slave (
    input  rd_req_i, wr_req_i, t_ccd_i, t_rtw_i, t_wtr_i, rd_ret_i,
    output rd_gnt_o, wr_gnt_o, bus_dir_o, rd_cred_o, err_o
  );

endinterface

// File: rtl/sal_gap_timer.sv
// Loadable down-counter that parks at zero; done is high whenever the count is zero.
module sal_gap_timer
  import sal_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/sal_rw_turnaround_arb.sv
// Read/write arbiter for the shared DFI data bus: tCCD spacing, tRTW/tWTR turnarounds,
// anti-starvation streak limit and read-credit tracking against the read return path.
module sal_rw_turnaround_arb
  import sal_sched_pkg::*;
#(
  parameter int MAX_RD_OUT = 8,
  parameter int MAX_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sal_rw_turnaround_arb_if.slave  bus
);

  localparam logic [TMR_W-1:0] RD_OUT_MAX = TMR_W'(MAX_RD_OUT);
  localparam logic [TMR_W-1:0] STREAK_MAX = TMR_W'(MAX_STREAK);

  arb_state_t       state_q, state_d;
  bus_dir_t         dir_q, dir_d;
  logic [TMR_W-1:0] streak_q, streak_d;
  logic [TMR_W-1:0] cred_q, cred_d;
  logic             err_q, err_d;

  logic             rd_ok, wr_ok;
  logic             rd_gnt, wr_gnt;
  logic             streak_full, cred_full;
  logic             gap_done, ta_done;
  logic             ta_load;
  logic [TMR_W-1:0] ta_val;
  logic [TMR_W-1:0] gap_val;

  assign streak_full = (streak_q == STREAK_MAX);
  assign cred_full   = (cred_q >= RD_OUT_MAX);
  assign gap_val     = ccd_gap(bus.t_ccd_i);

  // A direction yields once it has used its streak and the other side is waiting.
  assign rd_ok  = bus.rd_req_i & gap_done & ~cred_full & ~(bus.wr_req_i & streak_full);
  assign wr_ok  = bus.wr_req_i & gap_done & ~(bus.rd_req_i & streak_full);
  assign rd_gnt = rst_n & (state_q == ST_RD) & rd_ok;
  assign wr_gnt = rst_n & (state_q == ST_WR) & wr_ok;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    ta_load  = 1'b0;
    ta_val   = bus.t_rtw_i;
    streak_d = streak_q;
    if ((rd_gnt | wr_gnt) && !streak_full)
      streak_d = streak_q + 1'b1;

    case (state_q)
      ST_RD: begin
        if (!rd_ok && bus.wr_req_i && (!bus.rd_req_i || streak_full || cred_full)) begin
          state_d  = ST_R2W;
          dir_d    = DIR_WR;
          ta_load  = 1'b1;
          ta_val   = bus.t_rtw_i;
          streak_d = '0;
        end
      end
      ST_WR: begin
        if (!wr_ok && bus.rd_req_i && (!bus.wr_req_i || streak_full)) begin
          state_d  = ST_W2R;
          dir_d    = DIR_RD;
          ta_load  = 1'b1;
          ta_val   = bus.t_wtr_i;
          streak_d = '0;
        end
      end
      ST_R2W: if (ta_done && gap_done) state_d = ST_WR;
      ST_W2R: if (ta_done && gap_done) state_d = ST_RD;
      default: state_d = ST_RD;
    endcase
  end

  // Simultaneous grant and return cancel; a return with nothing outstanding is flagged, not counted.
  always_comb begin
    cred_d = cred_q;
    err_d  = err_q | (bus.rd_ret_i & (cred_q == '0));
    case ({rd_gnt, bus.rd_ret_i})
      2'b10:   cred_d = cred_q + 1'b1;
      2'b01:   if (cred_q != '0) cred_d = cred_q - 1'b1;
      default: cred_d = cred_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RD;
      dir_q    <= DIR_RD;
      streak_q <= '0;
      cred_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      streak_q <= streak_d;
      cred_q   <= cred_d;
      err_q    <= err_d;
    end
  end

  sal_gap_timer u_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rd_gnt | wr_gnt),
    .load_val (gap_val),
    .done     (gap_done)
  );

  sal_gap_timer u_ta (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ta_load),
    .load_val (ta_val),
    .done     (ta_done)
  );

  assign bus.rd_gnt_o  = rd_gnt;
  assign bus.wr_gnt_o  = wr_gnt;
  assign bus.bus_dir_o = (dir_q == DIR_WR);
  assign bus.rd_cred_o = cred_q;
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_sal_rw_turnaround_arb.sv
// Directed bench for sal_rw_turnaround_arb: credit limit, streak/turnaround cadence, credit corner
// cases, zero-length turnaround and reset during a turnaround.
module tb_sal_rw_turnaround_arb;
  import sal_sched_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  sal_rw_turnaround_arb_if bus ();

  sal_rw_turnaround_arb #(
    .MAX_RD_OUT (8),
    .MAX_STREAK (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] ccd, input logic [3:0] rtw, input logic [3:0] wtr);
    rst_n        = 1'b0;
    bus.rd_req_i = 1'b0;
    bus.wr_req_i = 1'b0;
    bus.rd_ret_i = 1'b0;
    bus.t_ccd_i  = ccd;
    bus.t_rtw_i  = rtw;
    bus.t_wtr_i  = wtr;
    repeat (2) next_cyc();
    rst_n = 1'b1;
  endtask

  // Grants must be exclusive and absent while turning the bus around.
  always @(negedge clk) begin
    chk("onehot", {31'd0, bus.rd_gnt_o & bus.wr_gnt_o}, 32'd0);
    chk("ta_nogrant", {31'd0, ((dut.state_q == ST_R2W) || (dut.state_q == ST_W2R)) &&
                               (bus.rd_gnt_o || bus.wr_gnt_o)}, 32'd0);
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // Reset state, with a read pending so the grant gate is actually exercised.
    rst_n        = 1'b0;
    bus.rd_req_i = 1'b1;
    bus.wr_req_i = 1'b0;
    bus.rd_ret_i = 1'b0;
    bus.t_ccd_i  = 4'd2;
    bus.t_rtw_i  = 4'd0;
    bus.t_wtr_i  = 4'd0;
    next_cyc();
    @(negedge clk);
    chk("rst_rd_gnt", {31'd0, bus.rd_gnt_o}, 32'd0);
    chk("rst_dir", {31'd0, bus.bus_dir_o}, 32'd0);
    chk("rst_cred", {28'd0, bus.rd_cred_o}, 32'd0);
    chk("rst_err", {31'd0, bus.err_o}, 32'd0);

    // Credit limit: tCCD=2 gives grants on even cycles until 8 are outstanding.
    do_reset(4'd2, 4'd0, 4'd0);
    bus.rd_req_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("t1_rd_gnt", {31'd0, bus.rd_gnt_o}, {31'd0, (c % 2 == 0) && (c < 16)});
      next_cyc();
    end
    @(negedge clk);
    chk("t1_cred_full", {28'd0, bus.rd_cred_o}, 32'd8);
    next_cyc();
    bus.rd_ret_i = 1'b1;
    @(negedge clk);
    chk("t1_ret_nogrant", {31'd0, bus.rd_gnt_o}, 32'd0);
    next_cyc();
    bus.rd_ret_i = 1'b0;
    @(negedge clk);
    chk("t1_ret_cred", {28'd0, bus.rd_cred_o}, 32'd7);
    chk("t1_regrant", {31'd0, bus.rd_gnt_o}, 32'd1);
    next_cyc();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t1_after", {31'd0, bus.rd_gnt_o}, 32'd0);
      next_cyc();
    end
    @(negedge clk);
    chk("t1_cred_end", {28'd0, bus.rd_cred_o}, 32'd8);

    // Cadence with both requests: 4 rd, yield cycle, 4-cycle R2W, 4 wr, yield cycle, 6-cycle W2R.
    do_reset(4'd1, 4'd3, 4'd5);
    bus.rd_req_i = 1'b1;
    bus.wr_req_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      int p;
      p = c % 20;
      @(negedge clk);
      chk("t2_rd", {31'd0, bus.rd_gnt_o}, {31'd0, p < 4});
      chk("t2_wr", {31'd0, bus.wr_gnt_o}, {31'd0, (p >= 9) && (p <= 12)});
      chk("t2_dir", {31'd0, bus.bus_dir_o}, {31'd0, (p >= 5) && (p <= 13)});
      next_cyc();
    end

    // Grant and return together at 3 hold the count; a return at 0 sets the sticky error.
    do_reset(4'd1, 4'd0, 4'd0);
    bus.rd_req_i = 1'b1;
    repeat (3) next_cyc();
    bus.rd_ret_i = 1'b1;
    @(negedge clk);
    chk("t3_cred3", {28'd0, bus.rd_cred_o}, 32'd3);
    chk("t3_gnt_ret", {31'd0, bus.rd_gnt_o}, 32'd1);
    next_cyc();
    bus.rd_req_i = 1'b0;
    bus.rd_ret_i = 1'b0;
    @(negedge clk);
    chk("t3_cred_hold", {28'd0, bus.rd_cred_o}, 32'd3);
    next_cyc();
    bus.rd_ret_i = 1'b1;
    repeat (3) next_cyc();
    bus.rd_ret_i = 1'b0;
    @(negedge clk);
    chk("t3_cred0", {28'd0, bus.rd_cred_o}, 32'd0);
    chk("t3_err0", {31'd0, bus.err_o}, 32'd0);
    next_cyc();
    bus.rd_ret_i = 1'b1;
    next_cyc();
    bus.rd_ret_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t3_err_sticky", {31'd0, bus.err_o}, 32'd1);
      chk("t3_cred_floor", {28'd0, bus.rd_cred_o}, 32'd0);
      next_cyc();
    end

    // Write-only from RD with tRTW=0: decision cycle, one R2W cycle, then writes.
    do_reset(4'd1, 4'd0, 4'd0);
    bus.wr_req_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t4_rd", {31'd0, bus.rd_gnt_o}, 32'd0);
      chk("t4_wr", {31'd0, bus.wr_gnt_o}, {31'd0, c >= 2});
      chk("t4_dir", {31'd0, bus.bus_dir_o}, {31'd0, c >= 1});
      next_cyc();
    end

    // Reset while in W2R with three turnaround cycles left.
    do_reset(4'd1, 4'd0, 4'd5);
    bus.rd_req_i = 1'b1;
    bus.wr_req_i = 1'b1;
    repeat (11) next_cyc();
    @(negedge clk);
    chk("t5_w2r_dir", {31'd0, bus.bus_dir_o}, 32'd0);
    next_cyc();
    next_cyc();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_state_w2r", {30'd0, dut.state_q}, {30'd0, ST_W2R});
    chk("t5_cred_pre", {28'd0, bus.rd_cred_o}, 32'd4);
    chk("t5_rst_rd", {31'd0, bus.rd_gnt_o}, 32'd0);
    next_cyc();
    @(negedge clk);
    chk("t5_state_rd", {30'd0, dut.state_q}, {30'd0, ST_RD});
    chk("t5_dir", {31'd0, bus.bus_dir_o}, 32'd0);
    chk("t5_cred", {28'd0, bus.rd_cred_o}, 32'd0);
    chk("t5_rst_gate", {31'd0, bus.rd_gnt_o}, 32'd0);
    next_cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_first_rd", {31'd0, bus.rd_gnt_o}, 32'd1);
    chk("t5_first_wr", {31'd0, bus.wr_gnt_o}, 32'd0);
    next_cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
